// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and a video window from incoming VGA syncs,
// measures line/frame lengths and tracks lock against the nominal timing.
module vga_sync_decoder #(
    parameter int HD           = 640,
    parameter int H_SYNC_START = 656,
    parameter int HTOTAL       = 800,
    parameter int VD           = 480,
    parameter int V_SYNC_START = 513,
    parameter int VTOTAL       = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       pix_tick,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       locked,
    output logic       line_err,
    output logic       frame_err,
    output logic       frame_start,
    output logic [9:0] h_total,
    output logic [9:0] v_total
);

    localparam int          TO_LIMIT = 2 * HTOTAL;
    localparam int          TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [9:0]  X_LAST   = 10'(HTOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(VTOTAL - 1);
    localparam logic [9:0]  MEAS_MAX = 10'h3FF;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t          state, state_next;
    logic [3:0]      good_cnt, good_next;
    logic            rst_meta, rst_n;
    logic            hs_d, vs_d, h_valid, v_valid, bad_frame;
    logic [9:0]      h_meas, v_meas;
    logic [TO_W-1:0] to_cnt;
    logic            hs_edge, vs_edge, x_wrap, line_bad, frame_bad, timeout;
    logic [10:0]     line_len;

    // Reset asserts immediately but is released on a clock edge.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    assign hs_edge   = pix_tick & hsync_in & ~hs_d;
    assign vs_edge   = pix_tick & vsync_in & ~vs_d;
    assign x_wrap    = pix_tick & ~hs_edge & (x == X_LAST);
    assign line_len  = {1'b0, h_meas} + 11'd1;
    assign line_bad  = hs_edge & h_valid & (line_len != 11'(HTOTAL));
    assign frame_bad = vs_edge & v_valid & (v_meas != 10'(VTOTAL));
    // The timeout counter is separate from h_meas because 2*HTOTAL exceeds its saturation point.
    assign timeout   = pix_tick & ~hs_edge & (to_cnt == TO_W'(TO_LIMIT - 1));
    assign video_on  = locked && (x < 10'(HD)) && (y < 10'(VD));

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            h_total     <= '0;
            v_total     <= '0;
            h_meas      <= '0;
            v_meas      <= '0;
            to_cnt      <= '0;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            h_valid     <= 1'b0;
            v_valid     <= 1'b0;
            bad_frame   <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_err    <= line_bad;
            frame_err   <= frame_bad;
            frame_start <= vs_edge;
            if (pix_tick) begin
                hs_d <= hsync_in;
                vs_d <= vsync_in;

                if (hs_edge)          x <= 10'(H_SYNC_START);
                else if (x == X_LAST) x <= '0;
                else                  x <= x + 10'd1;

                if (vs_edge)     y <= 10'(V_SYNC_START);
                else if (x_wrap) y <= (y == Y_LAST) ? 10'd0 : y + 10'd1;

                if (hs_edge) begin
                    if (h_valid) h_total <= line_len[10] ? MEAS_MAX : line_len[9:0];
                    h_meas  <= '0;
                    to_cnt  <= '0;
                    h_valid <= 1'b1;
                end else begin
                    if (h_meas != MEAS_MAX)              h_meas <= h_meas + 10'd1;
                    if (to_cnt != TO_W'(TO_LIMIT))       to_cnt <= to_cnt + 1'b1;
                end

                // An hsync edge coinciding with vsync is the first line of the new frame.
                if (vs_edge) begin
                    if (v_valid) v_total <= v_meas;
                    v_meas  <= {9'd0, hs_edge};
                    v_valid <= 1'b1;
                end else if (hs_edge && v_meas != MEAS_MAX) begin
                    v_meas <= v_meas + 10'd1;
                end

                if (vs_edge)       bad_frame <= 1'b0;
                else if (line_bad) bad_frame <= 1'b1;

                if (timeout) begin
                    h_valid <= 1'b0;
                    v_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            locked   <= (state_next == LOCKED);
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        if (timeout) begin
            state_next = HUNT;
            good_next  = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (vs_edge) begin
                        state_next = CHECK;
                        good_next  = '0;
                    end
                end
                CHECK: begin
                    if (vs_edge) begin
                        if (bad_frame || line_bad || frame_bad) begin
                            good_next = '0;
                        end else begin
                            good_next = good_cnt + 4'd1;
                            if (good_next >= 4'(LOCK_FRAMES)) state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad) begin
                        state_next = HUNT;
                        good_next  = '0;
                    end
                end
                default: begin
                    state_next = HUNT;
                    good_next  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 16x10 raster so that
// lock, error, timeout, glitch and reset scenarios fit in a short run.
module tb_vga_sync_decoder;

    localparam int HD  = 8;
    localparam int HSS = 10;
    localparam int HT  = 16;
    localparam int VD  = 6;
    localparam int VSS = 8;
    localparam int VT  = 10;
    localparam int RUN_LIMIT = 2000;

    logic       clk = 1'b0;
    logic       reset, pix_tick, hsync_in, vsync_in;
    logic [9:0] x, y, h_total, v_total;
    logic       video_on, locked, line_err, frame_err, frame_start;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   gx, gy, llen, flen;
    logic hs_off = 1'b0;
    logic glitch = 1'b0;
    int   le_cnt = 0;
    int   fe_cnt = 0;
    int   fs_cnt = 0;

    vga_sync_decoder #(
        .HD(HD), .H_SYNC_START(HSS), .HTOTAL(HT),
        .VD(VD), .V_SYNC_START(VSS), .VTOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .pix_tick   (pix_tick),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .locked     (locked),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .frame_start(frame_start),
        .h_total    (h_total),
        .v_total    (v_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_pulses();
        le_cnt += int'(line_err);
        fe_cnt += int'(frame_err);
        fs_cnt += int'(frame_start);
    endtask

    // One pixel tick followed by three idle clocks; called and returns on a negedge.
    task automatic tick_at(input logic hs, input logic vs);
        hsync_in = hs;
        vsync_in = vs;
        pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
        count_pulses();
        if (glitch) hsync_in = 1'b1;
        @(negedge clk);
        count_pulses();
        @(negedge clk);
        count_pulses();
        if (glitch) hsync_in = hs;
        @(negedge clk);
    endtask

    task automatic step();
        logic hs, vs;
        hs = !hs_off && gx >= HSS && gx < HSS + 2;
        vs = gy >= VSS && gy < VSS + 2;
        tick_at(hs, vs);
        if (gx == llen - 1) begin
            gx = 0;
            gy = (gy == flen - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic run_to(input int ty, input int tx);
        int guard;
        guard = 0;
        while (!(gx == tx && gy == ty) && guard < RUN_LIMIT) begin
            step();
            guard++;
        end
        check("run_to_bound", 32'(guard < RUN_LIMIT), 32'd1);
    endtask

    task automatic relock();
        run_to(VSS, 0);
        step();
        run_to(VSS, 0);
        step();
        run_to(VSS, 0);
        check("relock_before", 32'(locked), 32'd0);
        step();
        check("relock_after", 32'(locked), 32'd1);
    endtask

    initial begin
        int tx, ty, vo_cnt, fs0;
        logic exp_vo;
        reset    = 1'b0;
        pix_tick = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        gx = 0; gy = 0; llen = HT; flen = VT;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_totals", 32'({h_total, v_total}), 32'd0);
        check("rst_flags", 32'({video_on, locked, line_err, frame_err, frame_start}), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // First hsync edge after reset: aligns x, no measurement yet.
        run_to(0, HSS);
        step();
        check("first_hs_x", 32'(x), 32'd10);
        check("first_hs_y", 32'(y), 32'd0);
        check("first_hs_htotal", 32'(h_total), 32'd0);
        check("first_hs_noerr", 32'(le_cnt), 32'd0);

        // Nominal lock over three vsync edges.
        run_to(VSS, 0);
        step();
        check("vs1_fs", 32'(fs_cnt), 32'd1);
        check("vs1_y", 32'(y), 32'd8);
        check("vs1_vtotal", 32'(v_total), 32'd0);
        check("vs1_htotal", 32'(h_total), 32'd16);
        check("vs1_locked", 32'(locked), 32'd0);
        run_to(VSS, 0);
        step();
        check("vs2_vtotal", 32'(v_total), 32'd10);
        check("vs2_locked", 32'(locked), 32'd0);
        run_to(VSS, 0);
        check("vs3_pre_locked", 32'(locked), 32'd0);
        step();
        check("vs3_locked", 32'(locked), 32'd1);
        check("vs3_fs", 32'(fs_cnt), 32'd3);
        check("nominal_le", 32'(le_cnt), 32'd0);
        check("nominal_fe", 32'(fe_cnt), 32'd0);

        // One full locked frame: coordinates track the raster and video_on windows it.
        vo_cnt = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tx = gx;
            ty = gy;
            exp_vo = (tx < HD) && (ty < VD);
            step();
            check("frame_x_y_von", 32'({x, y, video_on}), 32'({tx[9:0], ty[9:0], exp_vo}));
            vo_cnt += int'(video_on);
        end
        check("video_on_count", 32'(vo_cnt), 32'(HD * VD));
        check("frame_le", 32'(le_cnt), 32'd0);
        check("frame_htotal", 32'(h_total), 32'd16);
        check("frame_vtotal", 32'(v_total), 32'd10);

        // Line stretched to 17 ticks.
        run_to(2, 0);
        llen = HT + 1;
        run_to(3, 0);
        llen = HT;
        run_to(3, HSS);
        check("le_pre_locked", 32'(locked), 32'd1);
        step();
        check("le_pulse_count", 32'(le_cnt), 32'd1);
        check("le_htotal", 32'(h_total), 32'd17);
        check("le_locked", 32'(locked), 32'd0);
        run_to(4, HSS);
        step();
        check("le_next_htotal", 32'(h_total), 32'd16);
        relock();

        // Frame shortened to 9 lines.
        flen = VT - 1;
        run_to(0, 0);
        flen = VT;
        run_to(VSS, 0);
        check("fe_pre_locked", 32'(locked), 32'd1);
        step();
        check("fe_pulse_count", 32'(fe_cnt), 32'd1);
        check("fe_vtotal", 32'(v_total), 32'd9);
        check("fe_locked", 32'(locked), 32'd0);
        relock();
        check("fe_relock_le", 32'(le_cnt), 32'd1);

        // hsync held low: timeout 32 ticks after the last edge at (8,10).
        run_to(VSS, HSS + 1);
        hs_off = 1'b1;
        run_to(0, HSS);
        check("to_pre_locked", 32'(locked), 32'd1);
        step();
        check("to_locked", 32'(locked), 32'd0);
        step();
        hs_off = 1'b0;
        run_to(1, HSS);
        step();
        check("to_first_edge_le", 32'(le_cnt), 32'd1);
        check("to_first_edge_htotal", 32'(h_total), 32'd16);
        check("to_first_edge_x", 32'(x), 32'd10);
        run_to(VSS, 0);
        step();
        check("to_first_vs_fe", 32'(fe_cnt), 32'd1);
        run_to(VSS, 0);
        step();
        run_to(VSS, 0);
        step();
        check("to_relock", 32'(locked), 32'd1);

        // Two-clock hsync glitch between ticks is ignored.
        run_to(9, 3);
        glitch = 1'b1;
        step();
        glitch = 1'b0;
        check("gl_x0", 32'(x), 32'd3);
        step();
        check("gl_x1", 32'(x), 32'd4);
        run_to(9, HSS);
        step();
        check("gl_edge_x", 32'(x), 32'd10);
        check("gl_le", 32'(le_cnt), 32'd1);
        check("gl_htotal", 32'(h_total), 32'd16);
        check("gl_locked", 32'(locked), 32'd1);

        // Mid-frame asynchronous reset.
        run_to(3, 6);
        check("mr_pre_xy", 32'({x, y}), 32'({10'd5, 10'd3}));
        check("mr_pre_von", 32'(video_on), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("mr_xy", 32'({x, y}), 32'd0);
        check("mr_totals", 32'({h_total, v_total}), 32'd0);
        check("mr_flags", 32'({video_on, locked, line_err, frame_err, frame_start}), 32'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        run_to(3, HSS);
        step();
        check("mr_edge_x", 32'(x), 32'd10);
        check("mr_edge_le", 32'(le_cnt), 32'd1);
        check("mr_edge_htotal", 32'(h_total), 32'd0);
        run_to(4, HSS);
        step();
        check("mr_2nd_htotal", 32'(h_total), 32'd16);
        fs0 = fs_cnt;
        run_to(VSS, 0);
        step();
        check("mr_vs_fs", 32'(fs_cnt), 32'(fs0 + 1));
        check("mr_vs_fe", 32'(fe_cnt), 32'd1);
        check("mr_vs_vtotal", 32'(v_total), 32'd0);
        check("mr_vs_locked", 32'(locked), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
